// File: rtl/spi_master_byte_pkg.sv
// rtl/spi_master_byte_pkg.sv - shared types and constants for the byte SPI master
package spi_master_byte_pkg;

    localparam int BYTE_W = 8;
    localparam int BIT_W  = $clog2(BYTE_W);

    // {CPOL, CPHA}; this master only implements mode 0
    localparam logic [1:0] SPI_MODE = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_master_byte_if.sv
// rtl/spi_master_byte_if.sv - host handshake and SPI pin bundle
interface spi_master_byte_if;
    import spi_master_byte_pkg::*;

    logic              tx_valid;
    logic              tx_ready;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_last;
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              busy;
    logic              SCK;
    logic              SSEL;
    logic              MOSI;
    logic              MISO;

    modport master (
        input  tx_valid, tx_data, tx_last, MISO,
        output tx_ready, rx_valid, rx_data, busy, SCK, SSEL, MOSI
    );

    modport slave (
        output tx_valid, tx_data, tx_last, MISO,
        input  tx_ready, rx_valid, rx_data, busy, SCK, SSEL, MOSI
    );

endinterface

// File: rtl/spi_master_byte_clk_div.sv
// rtl/spi_master_byte_clk_div.sv - loadable half-period down-counter with terminal count
module spi_clk_div #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // Load starts a phase of load_val+1 cycles; the counter parks at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/spi_master_byte.sv
// rtl/spi_master_byte.sv - byte-oriented mode-0 SPI master, MSB first, single slave
module spi_master_byte
    import spi_master_byte_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SSEL_GAP = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_master_byte_if.master     bus
);

    localparam int   CNT_MAX = max_int(CLK_DIV, SSEL_GAP);
    localparam int   CNT_W   = $clog2(CNT_MAX);
    localparam logic CPOL    = SPI_MODE[1];

    state_t            state, state_n;
    logic              sck, sck_n;
    logic              ssel, ssel_n;
    logic              mosi, mosi_n;
    logic              last_q, last_n;
    logic              rx_valid_q, rx_valid_n;
    logic [BYTE_W-1:0] sh, sh_n;
    logic [BYTE_W-1:0] rx_sh, rx_sh_n;
    logic [BYTE_W-1:0] rx_data_q, rx_data_n;
    logic [BIT_W-1:0]  bitcnt, bitcnt_n;
    logic              miso_q1, miso_s;
    logic              div_load, div_tc;
    logic [CNT_W-1:0]  div_val;
    logic              start;
    logic              last_bit;
    logic              tx_ready;
    logic              accept;

    spi_clk_div #(.W(CNT_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .load_val (div_val),
        .tc       (div_tc)
    );

    assign last_bit = (bitcnt == BIT_W'(BYTE_W - 1));
    // A byte can chain onto the previous one only in the very last LOW cycle
    assign tx_ready = (state == ST_IDLE) || (state == ST_WAIT) ||
                      ((state == ST_LOW) && last_bit && div_tc && !last_q);
    assign accept   = bus.tx_valid && tx_ready;

    // Two-flop synchroniser for the asynchronous MISO line
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_q1 <= 1'b0;
            miso_s  <= 1'b0;
        end else begin
            miso_q1 <= bus.MISO;
            miso_s  <= miso_q1;
        end
    end

    // State and registered pin/data values
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sck        <= 1'b0;
            ssel       <= 1'b1;
            mosi       <= 1'b0;
            last_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            sh         <= '0;
            rx_sh      <= '0;
            rx_data_q  <= '0;
            bitcnt     <= '0;
        end else begin
            state      <= state_n;
            sck        <= sck_n;
            ssel       <= ssel_n;
            mosi       <= mosi_n;
            last_q     <= last_n;
            rx_valid_q <= rx_valid_n;
            sh         <= sh_n;
            rx_sh      <= rx_sh_n;
            rx_data_q  <= rx_data_n;
            bitcnt     <= bitcnt_n;
        end
    end

    // Next-state and next-pin logic; pin values take effect as a phase begins
    always_comb begin
        state_n    = state;
        sck_n      = sck;
        ssel_n     = ssel;
        mosi_n     = mosi;
        last_n     = last_q;
        rx_valid_n = 1'b0;
        sh_n       = sh;
        rx_sh_n    = rx_sh;
        rx_data_n  = rx_data_q;
        bitcnt_n   = bitcnt;
        div_load   = 1'b0;
        div_val    = CNT_W'(CLK_DIV - 1);
        start      = 1'b0;

        case (state)
            ST_IDLE, ST_WAIT: begin
                start = accept;
            end
            ST_SETUP: begin
                if (div_tc) begin
                    sck_n    = 1'b1;
                    div_load = 1'b1;
                    state_n  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (div_tc) begin
                    // Sampling at the end of HIGH gives the slave's MISO plus our
                    // synchroniser the whole phase to settle
                    rx_sh_n  = {rx_sh[BYTE_W-2:0], miso_s};
                    sck_n    = 1'b0;
                    div_load = 1'b1;
                    state_n  = ST_LOW;
                    if (!last_bit) begin
                        sh_n   = {sh[BYTE_W-2:0], 1'b0};
                        mosi_n = sh[BYTE_W-2];
                    end else begin
                        rx_valid_n = 1'b1;
                        rx_data_n  = {rx_sh[BYTE_W-2:0], miso_s};
                    end
                end
            end
            ST_LOW: begin
                if (div_tc) begin
                    if (!last_bit) begin
                        bitcnt_n = bitcnt + 1'b1;
                        sck_n    = 1'b1;
                        div_load = 1'b1;
                        state_n  = ST_HIGH;
                    end else if (last_q) begin
                        ssel_n   = 1'b1;
                        mosi_n   = 1'b0;
                        div_load = 1'b1;
                        div_val  = CNT_W'(SSEL_GAP - 1);
                        state_n  = ST_GAP;
                    end else if (accept) begin
                        start = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_GAP: begin
                if (div_tc) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Accepting a byte always begins a full SETUP phase with bit 7 on MOSI
        if (start) begin
            sh_n     = bus.tx_data;
            last_n   = bus.tx_last;
            ssel_n   = 1'b0;
            sck_n    = 1'b0;
            mosi_n   = bus.tx_data[BYTE_W-1];
            bitcnt_n = '0;
            div_load = 1'b1;
            div_val  = CNT_W'(CLK_DIV - 1);
            state_n  = ST_SETUP;
        end
    end

    assign bus.tx_ready = tx_ready;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.SCK      = sck ^ CPOL;
    assign bus.SSEL     = ssel;
    assign bus.MOSI     = mosi;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// tb/tb_spi_master_byte.sv - directed bench for spi_master_byte with a mode-0 slave model
module tb_spi_master_byte;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slv;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
        int         exp_low;
        int         exp_gap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sel = 1'b0;
    logic       noise_en = 1'b0;
    logic       mon_clr = 1'b0;
    logic [7:0] slv_bytes [0:7];

    logic       miso_true = 1'b0;
    logic       noise = 1'b0;
    logic       sck_w, ssel_w, mosi_w, busy_w, tx_ready_w, rx_valid_w;
    logic [7:0] rx_data_w;

    logic [7:0] rx_q [$];
    logic [7:0] mosi_q [$];
    int         low_len = 0, last_low_len = 0, low_windows = 0, sck_rises = 0, viol = 0;
    int         hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_master_byte_if bus4();
    spi_master_byte_if bus7();

    spi_master_byte #(.CLK_DIV(4), .SSEL_GAP(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    spi_master_byte #(.CLK_DIV(7), .SSEL_GAP(3)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

    assign bus4.tx_valid = tx_valid & ~sel;
    assign bus4.tx_data  = tx_data;
    assign bus4.tx_last  = tx_last;
    assign bus4.MISO     = miso_true ^ noise;
    assign bus7.tx_valid = tx_valid & sel;
    assign bus7.tx_data  = tx_data;
    assign bus7.tx_last  = tx_last;
    assign bus7.MISO     = miso_true ^ noise;

    assign sck_w      = sel ? bus7.SCK      : bus4.SCK;
    assign ssel_w     = sel ? bus7.SSEL     : bus4.SSEL;
    assign mosi_w     = sel ? bus7.MOSI     : bus4.MOSI;
    assign busy_w     = sel ? bus7.busy     : bus4.busy;
    assign tx_ready_w = sel ? bus7.tx_ready : bus4.tx_ready;
    assign rx_valid_w = sel ? bus7.rx_valid : bus4.rx_valid;
    assign rx_data_w  = sel ? bus7.rx_data  : bus4.rx_data;

    // Slave model and bus monitor, evaluated on the falling clk edge
    initial begin
        logic       prev_sck, prev_ssel, prev_mosi, seen_fall;
        logic [7:0] s_byte, m_sh;
        logic [2:0] s_idx;
        int         s_bit, m_cnt, run, hcnt, cur_div;
        prev_sck = 0; prev_ssel = 1; prev_mosi = 0; seen_fall = 0;
        s_byte = 0; m_sh = 0; s_idx = 0; s_bit = 0; m_cnt = 0; run = 0; hcnt = 0;
        forever begin
            @(negedge clk);
            cur_div = sel ? 7 : 4;
            if (mon_clr) begin
                rx_q.delete();
                mosi_q.delete();
                m_cnt = 0; s_idx = 0; low_windows = 0; last_low_len = 0; sck_rises = 0;
                hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
            end else begin
                if (!ssel_w && prev_ssel) begin
                    s_byte = slv_bytes[s_idx]; s_idx = s_idx + 3'd1; s_bit = 0; m_cnt = 0;
                end
                if (ssel_w && !prev_ssel) begin
                    last_low_len = low_len; low_windows++; m_cnt = 0;
                end
                if (!ssel_w) low_len = prev_ssel ? 1 : low_len + 1;
                if (!ssel_w && sck_w && !prev_sck) begin
                    m_sh = {m_sh[6:0], mosi_w}; m_cnt++; sck_rises++;
                    if (m_cnt == 8) begin mosi_q.push_back(m_sh); m_cnt = 0; end
                end
                if (!ssel_w && !sck_w && prev_sck) begin
                    s_bit++;
                    if (s_bit == 8) begin s_byte = slv_bytes[s_idx]; s_idx = s_idx + 3'd1; s_bit = 0; end
                end
                if (rx_valid_w) rx_q.push_back(rx_data_w);
                if (sck_w == prev_sck) run++;
                else begin
                    if (prev_sck) begin
                        if (run < hi_min) hi_min = run;
                        if (run > hi_max) hi_max = run;
                        seen_fall = 1;
                    end else if (seen_fall) begin
                        if (run < lo_min) lo_min = run;
                        if (run > lo_max) lo_max = run;
                    end
                    run = 1;
                end
                if (ssel_w) seen_fall = 0;
                if (ssel_w && sck_w) viol++;
                if (mosi_w != prev_mosi && sck_w) viol++;
            end
            miso_true = s_byte[7 - s_bit];
            hcnt = (sck_w && prev_sck) ? hcnt + 1 : 0;
            noise = (noise_en && !(sck_w && hcnt == cur_div - 3)) ? 1'($urandom_range(1, 0)) : 1'b0;
            prev_sck = sck_w; prev_ssel = ssel_w; prev_mosi = mosi_w;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int ok;
        ok = 0;
        tx_valid = 1'b1; tx_data = d; tx_last = last;
        for (int i = 0; i < 500; i++) begin
            if (tx_ready_w) begin ok = 1; tick(); break; end
            tick();
        end
        check("accept_timeout", ok, 1);
    endtask

    task automatic wait_done(output int gap);
        int ok;
        ok = 0; gap = 0;
        for (int i = 0; i < 2000; i++) begin
            if (ssel_w) begin ok = 1; break; end
            tick();
        end
        check("ssel_rise_timeout", ok, 1);
        for (int i = 0; i < 100; i++) begin
            if (tx_ready_w) break;
            gap++;
            tick();
        end
    endtask

    function automatic int q_at(input int idx, input logic is_rx);
        if (is_rx) return (rx_q.size() > idx) ? int'(rx_q[idx]) : -1;
        return (mosi_q.size() > idx) ? int'(mosi_q[idx]) : -1;
    endfunction

    initial begin
        vec_t vecs [4];
        int   gap, n, ok, bad;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 68, 8};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 68, 8};
        vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 68, 8};
        vecs[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E, 68, 8};
        for (int i = 0; i < 8; i++) slv_bytes[i] = 8'h00;

        repeat (3) tick();
        check("rst_ssel", ssel_w, 1);
        check("rst_sck", sck_w, 0);
        check("rst_mosi", mosi_w, 0);
        check("rst_busy", busy_w, 0);
        check("rst_rx_valid", rx_valid_w, 0);
        check("rst_rx_data", rx_data_w, 0);
        rst = 1'b0;
        tick();
        check("idle_tx_ready", tx_ready_w, 1);

        for (int v = 0; v < 4; v++) begin
            clear_mon();
            slv_bytes[0] = vecs[v].slv;
            send_byte(vecs[v].tx, 1'b1);
            tx_valid = 1'b0;
            wait_done(gap);
            check($sformatf("v%0d_ssel_low", v), last_low_len, vecs[v].exp_low);
            check($sformatf("v%0d_gap", v), gap, vecs[v].exp_gap);
            check($sformatf("v%0d_rx_count", v), rx_q.size(), 1);
            check($sformatf("v%0d_rx_data", v), q_at(0, 1'b1), vecs[v].exp_rx);
            check($sformatf("v%0d_mosi", v), q_at(0, 1'b0), vecs[v].exp_mosi);
        end

        clear_mon();
        slv_bytes[0] = 8'h00; slv_bytes[1] = 8'h01; slv_bytes[2] = 8'h01;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        tx_valid = 1'b0;
        wait_done(gap);
        check("b2b_windows", low_windows, 1);
        check("b2b_ssel_low", last_low_len, 204);
        check("b2b_rx_count", rx_q.size(), 3);
        check("b2b_rx0", q_at(0, 1'b1), 8'h00);
        check("b2b_rx1", q_at(1, 1'b1), 8'h01);
        check("b2b_rx2", q_at(2, 1'b1), 8'h01);
        check("b2b_mosi2", q_at(2, 1'b0), 8'h03);

        clear_mon();
        slv_bytes[0] = 8'h96; slv_bytes[1] = 8'h4B;
        send_byte(8'h10, 1'b0);
        tx_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (rx_q.size() == 1) begin ok = 1; break; end
            tick();
        end
        check("stall_first_rx", ok, 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (sck_w || ssel_w) bad++;
            tick();
        end
        check("stall_pins", bad, 0);
        check("stall_ready", tx_ready_w, 1);
        check("stall_busy", busy_w, 1);
        send_byte(8'h20, 1'b1);
        tx_valid = 1'b0;
        n = 0;
        while (!sck_w && n < 50) begin n++; tick(); end
        check("stall_setup_len", n, 4);
        wait_done(gap);
        check("stall_windows", low_windows, 1);
        check("stall_rx1", q_at(1, 1'b1), 8'h4B);
        check("stall_mosi0", q_at(0, 1'b0), 8'h10);
        check("stall_mosi1", q_at(1, 1'b0), 8'h20);

        clear_mon();
        slv_bytes[0] = 8'hFF;
        send_byte(8'hC3, 1'b1);
        tx_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (sck_rises >= 4 && sck_w) begin ok = 1; break; end
            tick();
        end
        check("mid_rst_reach", ok, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_ssel", ssel_w, 1);
        check("mid_rst_sck", sck_w, 0);
        check("mid_rst_busy", busy_w, 0);
        check("mid_rst_rx_valid", rx_valid_w, 0);
        check("mid_rst_rx_data", rx_data_w, 0);
        rst = 1'b0;
        repeat (40) tick();
        check("mid_rst_no_rx", rx_q.size(), 0);
        clear_mon();
        slv_bytes[0] = 8'h69;
        send_byte(8'hFF, 1'b1);
        tx_valid = 1'b0;
        wait_done(gap);
        check("post_rst_rx", q_at(0, 1'b1), 8'h69);
        check("post_rst_mosi", q_at(0, 1'b0), 8'hFF);
        check("post_rst_low", last_low_len, 68);

        noise_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            slv_bytes[0] = (k == 0) ? 8'hB4 : 8'h2B;
            send_byte(8'h6D, 1'b1);
            tx_valid = 1'b0;
            wait_done(gap);
            check($sformatf("noise%0d_rx", k), q_at(0, 1'b1), (k == 0) ? 8'hB4 : 8'h2B);
        end
        noise_en = 1'b0;

        sel = 1'b1;
        tick();
        clear_mon();
        slv_bytes[0] = 8'hC3;
        send_byte(8'h5A, 1'b1);
        tx_valid = 1'b0;
        wait_done(gap);
        check("d7_ssel_low", last_low_len, 119);
        check("d7_gap", gap, 3);
        check("d7_hi_min", hi_min, 7);
        check("d7_hi_max", hi_max, 7);
        check("d7_lo_min", lo_min, 7);
        check("d7_lo_max", lo_max, 7);
        check("d7_rx", q_at(0, 1'b1), 8'hC3);
        check("d7_mosi", q_at(0, 1'b0), 8'h5A);

        check("pin_rules", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, single slave.
- Generates SCK, SSEL (active low) and MOSI, and samples MISO.
- Drives our FPGA SPI slave blocks from the host-side logic, and serves as the bus master in slave testbenches.
- The slave samples MOSI on SCK rising edges and updates MISO on falling edges, so this block times every edge for a slave that 3-stage-synchronises SCK and SSEL.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period. Must be at least 4 so the slave's synchroniser can resolve each edge.
- SSEL_GAP, 8, minimum clk cycles SSEL is held high between messages.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- tx_valid  in  1  host offers a byte.
- tx_ready  out  1  block accepts the byte in any cycle where tx_valid && tx_ready.
- tx_data  in  8  byte to send.
- tx_last  in  1  accepted byte is the final byte of the message; SSEL rises after it.
- rx_valid  out  1  one-cycle pulse: rx_data holds a byte received from the slave.
- rx_data  out  8  received byte.
- busy  out  1  high whenever the state is not IDLE.
- SCK  out  1  SPI clock.
- SSEL  out  1  slave select, active low.
- MOSI  out  1  master out.
- MISO  in  1  slave out. Asynchronous; passed through a 2-flop synchroniser before use.

Behaviour:
- Reset (also when asserted mid-transfer): next cycle state=IDLE, SCK=0, SSEL=1, MOSI=0, rx_valid=0, rx_data=0, busy=0. Any partial byte is discarded and no rx_valid is produced.
- States: IDLE, SETUP, HIGH, LOW, WAIT, GAP. Internal registers: divider count div (0..CLK_DIV-1), bit counter bitcnt (0..7), shift register sh[7:0], last_q.
- tx_ready = (IDLE) | (WAIT) | (LOW && bitcnt==7 && div==CLK_DIV-1 && !last_q).
- IDLE: on accept, capture sh=tx_data and last_q=tx_last, set SSEL=0, bitcnt=0, go to SETUP.
- SETUP: CLK_DIV cycles with SCK=0 and MOSI=sh[7]. Then SCK=1 and go to HIGH.
- HIGH: CLK_DIV cycles with SCK=1. In the last HIGH cycle, shift the synchronised MISO into the receive register (late sample absorbs the slave's MISO lag). Then SCK=0 and go to LOW.
- LOW, first cycle:
  - If bitcnt<7: shift sh left, MOSI=new sh[7].
  - If bitcnt==7: rx_valid=1 for this single cycle, rx_data=assembled byte.
- LOW, last cycle:
  - bitcnt<7: bitcnt++, SCK=1, go to HIGH.
  - bitcnt==7 && last_q: SSEL=1, go to GAP.
  - bitcnt==7 && !last_q && tx_valid: accept the byte, go to SETUP. SSEL stays low.
  - bitcnt==7 && !last_q && !tx_valid: go to WAIT.
- WAIT: SCK=0, SSEL=0; hold until a byte is accepted, then go to SETUP. A message may stall indefinitely.
- GAP: SSEL_GAP cycles with SSEL=1, then go to IDLE. tx_ready=0 throughout.
- Timing: a single-byte message holds SSEL low for exactly 17*CLK_DIV cycles. With tx_valid held, N back-to-back bytes take 17*N*CLK_DIV cycles.
- The SCK rising edge always occurs at least CLK_DIV cycles after MOSI changes; MOSI changes only while SCK=0.
- SCK=0 whenever SSEL=1.
- tx_data and tx_last are ignored except in an accept cycle.

Decomposition:
- Shared package: the state enum encoding, the SPI mode constant (mode 0), and the byte width constant 8.
- One natural sub-module: spi_clk_div, a half-period down-counter with load and terminal-count outputs, reusable by other SPI/I2C masters.
- The 2-flop MISO synchroniser stays inline.

Test Plan:
- Reset, then tx 0xA5 with tx_last=1; slave model returns 0x3C.
  - Expect MOSI sampled at rising edges = 1,0,1,0,0,1,0,1.
  - Expect exactly one rx_valid pulse with rx_data=0x3C.
  - Expect SSEL low for 68 clk (CLK_DIV=4), then high for at least 8 clk before tx_ready rises.
- tx_valid held high; send 0x01, 0x02, 0x03 (last on 0x03); slave is a fibonacci model returning 0x00, 0x01, 0x01.
  - Expect a single SSEL low window of 204 clk.
  - Expect 3 rx_valid pulses with those values, in order.
- Send 0x10 with tx_last=0, then drop tx_valid for 50 clk, then send 0x20 with tx_last=1.
  - Expect SCK=0 and SSEL=0 throughout the stall.
  - Expect the second byte to start with a full SETUP phase.
- Assert rst in the 4th HIGH phase of a byte.
  - Expect next cycle SSEL=1, SCK=0, busy=0, and no rx_valid.
  - A following transfer of 0xFF completes correctly.
- MISO toggled randomly in clk cycles away from the sample point, while the slave's true bit is stable.
  - Expect rx_data to match the slave bits.
  - Expect the MISO sample only in the last HIGH cycle.
- CLK_DIV=7, SSEL_GAP=3: send a single byte.
  - Expect SCK high and low phases of exactly 7 clk each.
  - Expect SSEL low for 119 clk, then high for 3 clk.
